// File: rtl/edabk_ckpt_pkg.sv
// Shared definitions for the checkpoint port: register map, STATUS/CTRL bit
// positions and the display FSM state encoding.
package edabk_ckpt_pkg;

  // Byte offsets inside the 256-byte Wishbone window
  localparam logic [7:0] OFF_CODE   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;

  // STATUS register fields
  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_LVL_LSB = 4;

  // CTRL register fields
  localparam int CTRL_DRIVE_EN = 0;
  localparam int CTRL_OVF_CLR  = 1;
  localparam int CTRL_IRQ_EN   = 2;

  // Display scheduler states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } ckpt_state_e;

endpackage

// File: rtl/edabk_ckpt_fifo.sv
// Synchronous FIFO holding checkpoint codes waiting to be shown on the pins.
// A pop and a push in the same cycle are both honoured even when full, so a
// code written while the scheduler drains the head is never lost.
module edabk_ckpt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array write port
  // NOTE: the data array has no reset; pointers and count define validity,
  // and leaving it unreset lets it map onto plain flops/RAM without a reset tree.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + LW'(1);
      else if (do_pop && !do_push) count_q <= count_q - LW'(1);
    end
  end

endmodule

// File: rtl/edabk_checkpoint_port.sv
// Wishbone-mapped checkpoint port: software pushes 16-bit codes, and a small
// scheduler shows each one on mprj_io[31:16] for at least HOLD_CYCLES cycles.
// Optional feature macro: EDABK_CKPT_IRQ_EN (overflow interrupt + CTRL.irq_en).
module edabk_checkpoint_port
  import edabk_ckpt_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HOLD_CYCLES = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] ckpt_out,
  output logic [15:0] ckpt_oeb,
  output logic        irq_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES);

  // Bus-side registers
  logic        ack_q;
  logic [31:0] dat_q, dat_d;
  logic        drive_en_q;
  logic        ovf_q;
  logic        irq_en;

  // Scheduler registers
  ckpt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      display_q, display_d;
  logic             pop;

  // FIFO interface
  logic [15:0]      fifo_head;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;

  // Window decode; a transfer is accepted once, on the cycle before its ack
  logic       hit, acc, wr_code, wr_ctrl, ovf_set, ovf_clr;
  logic [7:0] off;

  assign hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off     = wbs_adr_i[7:0];
  assign acc     = wbs_cyc_i && wbs_stb_i && hit && !ack_q;
  assign wr_code = acc && wbs_we_i && (off == OFF_CODE) && (wbs_sel_i[1:0] == 2'b11);
  assign wr_ctrl = acc && wbs_we_i && (off == OFF_CTRL);
  // A drained head frees a slot in the same cycle, so only a real drop counts
  assign ovf_set = wr_code && fifo_full && !pop;
  assign ovf_clr = wr_ctrl && wbs_dat_i[CTRL_OVF_CLR];

  edabk_ckpt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (wr_code),
    .data_i  (wbs_dat_i[15:0]),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Read-data mux; unmapped offsets and writes return zero
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dat_d = '0;
    if (acc && !wbs_we_i) begin
      unique case (off)
        OFF_CODE:   dat_d[15:0] = display_q;
        OFF_STATUS: begin
          dat_d[STAT_EMPTY]             = fifo_empty;
          dat_d[STAT_FULL]              = fifo_full;
          dat_d[STAT_OVF]               = ovf_q;
          dat_d[STAT_LVL_LSB +: 4]      = 4'(fifo_level);
        end
        OFF_CTRL: begin
          dat_d[CTRL_DRIVE_EN] = drive_en_q;
          dat_d[CTRL_IRQ_EN]   = irq_en;
        end
        default:    dat_d = '0;
      endcase
    end
  end

  // Bus handshake, CTRL register and sticky overflow (set beats clear)
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      drive_en_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ack_q <= acc;
      dat_q <= dat_d;
      if (wr_ctrl) drive_en_q <= wbs_dat_i[CTRL_DRIVE_EN];
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

`ifdef EDABK_CKPT_IRQ_EN
  logic irq_en_q, irq_q;

  // Interrupt enable bit and registered overflow interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
      irq_q <= ovf_q && irq_en_q;
    end
  end

  assign irq_en = irq_en_q;
  assign irq_o  = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  // Bits that carry no meaning in this register map
  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i[31:16], wbs_sel_i[3:2], wbs_dat_i[CTRL_IRQ_EN]};

  // Scheduler state, hold counter and displayed code
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      display_q <= display_d;
    end
  end

  // Scheduler next state: wait for a code, latch it, then hold it on the pins
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    display_d = display_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        pop       = 1'b1;
        display_d = fifo_head;
        cnt_d     = CNT_W'(HOLD_CYCLES - 1);
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ckpt_out  = display_q;
  assign ckpt_oeb  = drive_en_q ? 16'h0000 : 16'hFFFF;

endmodule
